div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//  Requester side of the divider's req/ready handshake. Sits in EX between the pipeline and the
//  unsigned divider. Decodes RV32M DIV/DIVU/REM/REMU and converts signed operands to magnitudes.
//  Holds req to the divider until it completes, then sign-fixes the quotient/remainder.
//  Stalls the pipeline for the whole operation and returns one XLEN-bit result.
// PARAMETERS
//  XLEN  32  operand/result width
// PORTS
//  clk_i           in   1     clock; all state updates on rising edge
//  rst_i           in   1     reset, synchronous, active-high
//  valid_i         in   1     EX holds a divide-class op; held high by pipeline while stall_o=1
//  funct3_i        in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx => op ignored
//  rs1_i           in   XLEN  dividend
//  rs2_i           in   XLEN  divisor
//  flush_i         in   1     kill in-flight op (branch/trap)
//  stall_o         out  1     freeze pipeline
//  result_o        out  XLEN  final rd value, valid when result_valid_o=1
//  result_valid_o  out  1     one-cycle pulse, result_o valid
//  div_a_o         out  XLEN  |dividend| to divider
//  div_b_o         out  XLEN  |divisor| to divider
//  div_is_q_o      out  1     1 = quotient, 0 = remainder
//  div_req_o       out  1     request; divider idles whenever low
//  div_result_i    in   XLEN  unsigned divider result
//  div_ready_i     in   1     divider done pulse, div_result_i valid same cycle
// BEHAVIOUR
//  Reset: state=IDLE; stall_o=0, result_valid_o=0, div_req_o=0.
//  Reset: result_o, div_a_o, div_b_o, div_is_q_o all =0.
//  go = valid_i & funct3_i[2] & ~flush_i; sgn = ~funct3_i[0]; rem = funct3_i[1].
//  IDLE: on go latch the following, then -> BUSY:
//   - div_a_o = sgn&rs1[31] ? -rs1 : rs1; div_b_o likewise from rs2.
//   - div_is_q_o = ~rem.
//   - sa = sgn&rs1[31]; sb = sgn&rs2[31]; bz = (rs2==0).
//  BUSY: div_req_o = ~div_ready_i (combinational), so req is low in the ready cycle.
//   - This prevents a divider restart.
//   - Operand regs stay stable. On div_ready_i capture div_result_i into raw -> FIX.
//  FIX: register result_o:
//   - quotient:  negate raw iff (sa^sb) & ~bz; bz passes raw (all ones) unchanged.
//   - remainder: negate raw iff sa; bz gives rs1 back.
//   - Then -> DONE.
//  DONE: result_valid_o=1 for exactly this cycle -> IDLE. The pipeline advances at the end of DONE.
//  stall_o = (IDLE&go) | BUSY | FIX; stall_o is 0 in DONE.
//  Latency: go cycle to result_valid_o = divider latency + 3 cycles.
//   - Controller makes no assumption on divider latency.
//  Overflow 0x80000000 / -1: magnitudes 0x80000000/1, no negation. Result 0x80000000, rem 0.
//   - No special case needed.
//  flush_i in any state: next state IDLE, div_req_o low from next cycle, no result_valid_o.
//   - result_o keeps its last value. Flush takes priority over div_ready_i in the same cycle.
//  rst_i mid-op: same as flush, and all outputs go to their reset values.
//  valid_i dropping in BUSY/FIX without flush_i is illegal (pipeline contract); assert in sim.
// TESTING
//  DIVU 100/7 -> 14; REMU 100/7 -> 2; div_req_o low in the ready cycle.
//   - Exactly one result_valid_o pulse.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
//  Divide by zero:
//   - DIV 5/0 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF.
//   - REM -5/0 -> 0xFFFFFFFB; REMU 9/0 -> 9.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV 0/3 -> 0.
//  flush_i 5 cycles into BUSY -> div_req_o=0 next cycle, stall_o=0, no result_valid_o.
//   - Then DIVU 9/3 -> 3.
//  rst_i mid-BUSY -> all outputs reset next cycle; model divider latency 1 and 40, back-to-back ops.

Source files
------------

// File: rtl/div_ctrl_if.sv
// ============================================================================
//  Module      : div_ctrl_if
//  Description : Operand/result handshake between the EX divide controller
//                and the unsigned divider.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_is_q;
  logic            div_req;
  logic [XLEN-1:0] div_result;
  logic            div_ready;

  modport master (
    output div_a, div_b, div_is_q, div_req,
    input  div_result, div_ready
  );

  modport slave (
    input  div_a, div_b, div_is_q, div_req,
    output div_result, div_ready
  );
endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
//  Module      : div_ctrl
//  Description : RV32M DIV/DIVU/REM/REMU requester; stalls EX, feeds operand
//                magnitudes to an unsigned divider and sign-fixes its result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_ctrl #(
  parameter int XLEN = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  input  wire logic            valid_i,
  input  wire logic [2:0]      funct3_i,
  input  wire logic [XLEN-1:0] rs1_i,
  input  wire logic [XLEN-1:0] rs2_i,
  input  wire logic            flush_i,
  output logic                 stall_o,
  output logic [XLEN-1:0]      result_o,
  output logic                 result_valid_o,
  div_ctrl_if.master           div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_go;
  logic            w_sgn;
  logic            w_rem;
  logic            w_neg_a;
  logic            w_neg_b;
  logic            w_stall;
  logic            w_req;
  logic            w_res_vld;
  logic [XLEN-1:0] w_fixed;
  logic [XLEN-1:0] r_div_a;
  logic [XLEN-1:0] r_div_b;
  logic [XLEN-1:0] r_raw;
  logic [XLEN-1:0] r_result;
  logic            r_is_q;
  logic            r_sa;
  logic            r_sb;
  logic            r_bz;

  assign w_go    = valid_i & funct3_i[2] & ~flush_i;
  assign w_sgn   = ~funct3_i[0];
  assign w_rem   = funct3_i[1];
  assign w_neg_a = w_sgn & rs1_i[XLEN-1];
  assign w_neg_b = w_sgn & rs2_i[XLEN-1];

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_req       = 1'b0;
    w_res_vld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_go;
        if (w_go) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        // Drop req in the ready cycle so the divider does not restart.
        w_req   = ~div_if.div_ready;
        if (flush_i)               w_state_nxt = S_IDLE;
        else if (div_if.div_ready) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_stall     = 1'b1;
        w_state_nxt = flush_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_res_vld   = ~flush_i;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst_i) begin
      w_stall   = 1'b0;
      w_req     = 1'b0;
      w_res_vld = 1'b0;
    end
  end

  // Divide by zero: quotient passes the all-ones raw value, remainder is rs1.
  always_comb begin
    if (r_is_q)    w_fixed = ((r_sa ^ r_sb) & ~r_bz) ? -r_raw : r_raw;
    else if (r_bz) w_fixed = r_sa ? -r_div_a : r_div_a;
    else           w_fixed = r_sa ? -r_raw : r_raw;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_div_a  <= '0;
      r_div_b  <= '0;
      r_raw    <= '0;
      r_result <= '0;
      r_is_q   <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_go) begin
        r_div_a <= w_neg_a ? -rs1_i : rs1_i;
        r_div_b <= w_neg_b ? -rs2_i : rs2_i;
        r_is_q  <= ~w_rem;
        r_sa    <= w_neg_a;
        r_sb    <= w_neg_b;
        r_bz    <= (rs2_i == '0);
      end
      if (r_state == S_BUSY && div_if.div_ready && !flush_i) r_raw <= div_if.div_result;
      if (r_state == S_FIX && !flush_i) r_result <= w_fixed;
    end
  end

  assign stall_o         = w_stall;
  assign result_valid_o  = w_res_vld;
  assign result_o        = r_result;
  assign div_if.div_a    = r_div_a;
  assign div_if.div_b    = r_div_b;
  assign div_if.div_is_q = r_is_q;
  assign div_if.div_req  = w_req;

  // The pipeline must hold valid_i for the whole operation unless it flushes.
  a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    ((r_state == S_BUSY || r_state == S_FIX) && !flush_i) |-> valid_i);

endmodule

`default_nettype wire
